// File: rtl/decode_regfile.sv
// Y86-64 decode stage: srcA/srcB derivation, register file with a same-cycle writeback
// bypass on both read ports, and a stallable output register feeding execute.
module decode_regfile #(
  parameter int DATA_W     = 64,
  parameter int NREG       = 15,
  parameter int RESET_MODE = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  input  logic              stall,
  input  logic [3:0]        icode,
  input  logic [3:0]        rA,
  input  logic [3:0]        rB,
  input  logic [3:0]        dstE,
  input  logic [DATA_W-1:0] valE,
  input  logic [3:0]        dstM,
  input  logic [DATA_W-1:0] valM,
  output logic              out_valid,
  output logic [3:0]        out_icode,
  output logic [3:0]        out_srcA,
  output logic [3:0]        out_srcB,
  output logic [DATA_W-1:0] out_valA,
  output logic [DATA_W-1:0] out_valB
);

  localparam logic [3:0] RNONE = 4'hF;
  localparam logic [3:0] RSP   = 4'h4;

  logic [DATA_W-1:0] regs [NREG];
  logic [3:0]        src_a;
  logic [3:0]        src_b;
  logic [DATA_W-1:0] rd_a;
  logic [DATA_W-1:0] rd_b;

  always_comb begin
    src_a = RNONE;
    case (icode)
      4'h2, 4'h4, 4'h6, 4'hA: src_a = rA;
      4'h9, 4'hB:             src_a = RSP;
      default:                src_a = RNONE;
    endcase
  end

  always_comb begin
    src_b = RNONE;
    case (icode)
      4'h4, 4'h5, 4'h6:       src_b = rB;
      4'h8, 4'h9, 4'hA, 4'hB: src_b = RSP;
      default:                src_b = RNONE;
    endcase
  end

  // Only implemented IDs see the bypass; RNONE and IDs >= NREG read as zero.
  function automatic logic [DATA_W-1:0] read_port(
    input logic [3:0]        id,
    input logic [DATA_W-1:0] stored,
    input logic              hit
  );
    logic [DATA_W-1:0] r;
    r = '0;
    if (hit) begin
      if (dstM == id)      r = valM;
      else if (dstE == id) r = valE;
      else                 r = stored;
    end
    return r;
  endfunction

  always_comb begin
    logic              hit_a;
    logic              hit_b;
    logic [DATA_W-1:0] st_a;
    logic [DATA_W-1:0] st_b;
    hit_a = 1'b0;
    hit_b = 1'b0;
    st_a  = '0;
    st_b  = '0;
    for (int i = 0; i < NREG; i++) begin
      if (src_a == 4'(i)) begin
        hit_a = 1'b1;
        st_a  = regs[i];
      end
      if (src_b == 4'(i)) begin
        hit_b = 1'b1;
        st_b  = regs[i];
      end
    end
    rd_a = read_port(src_a, st_a, hit_a);
    rd_b = read_port(src_b, st_b, hit_b);
  end

  // M has priority over E when both target the same register (popq %rsp).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREG; i++)
        regs[i] <= (RESET_MODE == 1) ? DATA_W'(i) : '0;
    end else begin
      for (int i = 0; i < NREG; i++) begin
        if (dstM == 4'(i))      regs[i] <= valM;
        else if (dstE == 4'(i)) regs[i] <= valE;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_icode <= 4'h0;
      out_srcA  <= RNONE;
      out_srcB  <= RNONE;
      out_valA  <= '0;
      out_valB  <= '0;
    end else if (!stall) begin
      out_valid <= in_valid;
      if (in_valid) begin
        out_icode <= icode;
        out_srcA  <= src_a;
        out_srcB  <= src_b;
        out_valA  <= rd_a;
        out_valB  <= rd_b;
      end
    end
  end

endmodule

// File: tb/tb_decode_regfile.sv
// Self-checking bench: two instances (NREG=15 and NREG=8, both preloaded with i) against
// an array-based reference model, plus directed scenarios with literal expectations.
module tb_decode_regfile;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        stall;
  logic [3:0]  icode;
  logic [3:0]  rA;
  logic [3:0]  rB;
  logic [3:0]  dstE;
  logic [63:0] valE;
  logic [3:0]  dstM;
  logic [63:0] valM;

  logic        o_valid [2];
  logic [3:0]  o_icode [2];
  logic [3:0]  o_srcA  [2];
  logic [3:0]  o_srcB  [2];
  logic [63:0] o_valA  [2];
  logic [63:0] o_valB  [2];

  int n_checks = 0;
  int n_err    = 0;
  bit chk_en   = 0;

  decode_regfile #(.DATA_W(64), .NREG(15), .RESET_MODE(1)) u_dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .stall(stall),
    .icode(icode), .rA(rA), .rB(rB),
    .dstE(dstE), .valE(valE), .dstM(dstM), .valM(valM),
    .out_valid(o_valid[0]), .out_icode(o_icode[0]),
    .out_srcA(o_srcA[0]), .out_srcB(o_srcB[0]),
    .out_valA(o_valA[0]), .out_valB(o_valB[0])
  );

  decode_regfile #(.DATA_W(64), .NREG(8), .RESET_MODE(1)) u_dut8 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .stall(stall),
    .icode(icode), .rA(rA), .rB(rB),
    .dstE(dstE), .valE(valE), .dstM(dstM), .valM(valM),
    .out_valid(o_valid[1]), .out_icode(o_icode[1]),
    .out_srcA(o_srcA[1]), .out_srcB(o_srcB[1]),
    .out_valA(o_valA[1]), .out_valB(o_valB[1])
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ---------------- reference model ----------------
  logic [63:0] mr     [2][16];
  logic        e_valid[2];
  logic [3:0]  e_icode[2];
  logic [3:0]  e_srcA [2];
  logic [3:0]  e_srcB [2];
  logic [63:0] e_valA [2];
  logic [63:0] e_valB [2];

  function automatic int nreg_of(int k);
    return (k == 0) ? 15 : 8;
  endfunction

  function automatic logic [3:0] srca_of(logic [3:0] ic, logic [3:0] ra);
    if (ic == 4'h2 || ic == 4'h4 || ic == 4'h6 || ic == 4'hA) return ra;
    if (ic == 4'h9 || ic == 4'hB) return 4'h4;
    return 4'hF;
  endfunction

  function automatic logic [3:0] srcb_of(logic [3:0] ic, logic [3:0] rb);
    if (ic == 4'h4 || ic == 4'h5 || ic == 4'h6) return rb;
    if (ic == 4'h8 || ic == 4'h9 || ic == 4'hA || ic == 4'hB) return 4'h4;
    return 4'hF;
  endfunction

  function automatic logic [63:0] m_read(int k, logic [3:0] id);
    if (int'(id) >= nreg_of(k)) return 64'h0;
    if (dstM == id) return valM;
    if (dstE == id) return valE;
    return mr[k][id];
  endfunction

  always @(posedge clk or negedge rst_n) begin
    for (int k = 0; k < 2; k++) begin
      if (!rst_n) begin
        for (int i = 0; i < 16; i++) mr[k][i] <= 64'(i);
        e_valid[k] <= 1'b0;
        e_icode[k] <= 4'h0;
        e_srcA[k]  <= 4'hF;
        e_srcB[k]  <= 4'hF;
        e_valA[k]  <= 64'h0;
        e_valB[k]  <= 64'h0;
      end else begin
        if (!stall) begin
          e_valid[k] <= in_valid;
          if (in_valid) begin
            e_icode[k] <= icode;
            e_srcA[k]  <= srca_of(icode, rA);
            e_srcB[k]  <= srcb_of(icode, rB);
            e_valA[k]  <= m_read(k, srca_of(icode, rA));
            e_valB[k]  <= m_read(k, srcb_of(icode, rB));
          end
        end
        if (int'(dstE) < nreg_of(k)) mr[k][dstE] <= valE;
        if (int'(dstM) < nreg_of(k)) mr[k][dstM] <= valM;
      end
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      for (int k = 0; k < 2; k++) begin
        chk($sformatf("m%0d_valid", k), 64'(o_valid[k]), 64'(e_valid[k]));
        chk($sformatf("m%0d_icode", k), 64'(o_icode[k]), 64'(e_icode[k]));
        chk($sformatf("m%0d_srcA", k),  64'(o_srcA[k]),  64'(e_srcA[k]));
        chk($sformatf("m%0d_srcB", k),  64'(o_srcB[k]),  64'(e_srcB[k]));
        chk($sformatf("m%0d_valA", k),  o_valA[k],       e_valA[k]);
        chk($sformatf("m%0d_valB", k),  o_valB[k],       e_valB[k]);
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic drive(input logic [3:0] ic, input logic [3:0] ra, input logic [3:0] rb,
                       input logic [3:0] de, input logic [63:0] ve,
                       input logic [3:0] dm, input logic [63:0] vm,
                       input logic v, input logic s);
    icode = ic; rA = ra; rB = rb;
    dstE = de; valE = ve; dstM = dm; valM = vm;
    in_valid = v; stall = s;
  endtask

  initial begin
    rst_n = 1'b0;
    drive(4'h0, 4'hF, 4'hF, 4'hF, 64'h0, 4'hF, 64'h0, 1'b0, 1'b0);
    repeat (2) @(negedge clk);
    chk("rst_valid", 64'(o_valid[0]), 64'h0);
    chk("rst_srcA",  64'(o_srcA[0]),  64'hF);
    chk("rst_valA",  o_valA[0],       64'h0);
    rst_n  = 1'b1;
    chk_en = 1'b1;

    // 1: preload visible through rrmovq read of reg 3
    drive(4'h2, 4'h3, 4'h0, 4'hF, 64'h0, 4'hF, 64'h0, 1'b1, 1'b0);
    @(negedge clk);
    chk("t1_valA",  o_valA[0], 64'h3);
    chk("t1_srcA",  64'(o_srcA[0]), 64'h3);
    chk("t1_srcB",  64'(o_srcB[0]), 64'hF);
    chk("t1_valB",  o_valB[0], 64'h0);
    chk("t1_valid", 64'(o_valid[0]), 64'h1);

    // 2: E-port bypass, then the array holds the value
    drive(4'h6, 4'h1, 4'h2, 4'h1, 64'h55, 4'hF, 64'h0, 1'b1, 1'b0);
    @(negedge clk);
    chk("t2_valA_bypass", o_valA[0], 64'h55);
    chk("t2_valB",        o_valB[0], 64'h2);
    drive(4'h2, 4'h1, 4'h0, 4'hF, 64'h0, 4'hF, 64'h0, 1'b1, 1'b0);
    @(negedge clk);
    chk("t2_valA_array", o_valA[0], 64'h55);

    // 3: dstE == dstM, M wins
    drive(4'hB, 4'h0, 4'h0, 4'h4, 64'h10, 4'h4, 64'h20, 1'b1, 1'b0);
    @(negedge clk);
    chk("t3_valA", o_valA[0], 64'h20);
    chk("t3_valB", o_valB[0], 64'h20);
    drive(4'h2, 4'h4, 4'h0, 4'hF, 64'h0, 4'hF, 64'h0, 1'b1, 1'b0);
    @(negedge clk);
    chk("t3_reg4", o_valA[0], 64'h20);

    // 4: stall holds outputs while the write to reg 5 still lands
    drive(4'h2, 4'h3, 4'h0, 4'hF, 64'h0, 4'hF, 64'h0, 1'b1, 1'b0);
    @(negedge clk);
    for (int c = 0; c < 3; c++) begin
      drive(4'h6, 4'h1, 4'h1, 4'h5, 64'h77 + 64'(c), 4'hF, 64'h0, 1'b1, 1'b1);
      @(negedge clk);
      chk("t4_hold_valA",  o_valA[0], 64'h3);
      chk("t4_hold_icode", 64'(o_icode[0]), 64'h2);
      chk("t4_hold_srcB",  64'(o_srcB[0]), 64'hF);
    end
    drive(4'h4, 4'h5, 4'h0, 4'hF, 64'h0, 4'hF, 64'h0, 1'b1, 1'b0);
    @(negedge clk);
    chk("t4_valA_reg5", o_valA[0], 64'h79);
    chk("t4_valB_reg0", o_valB[0], 64'h0);

    // 5: RNONE and out-of-range IDs
    drive(4'h2, 4'hF, 4'h0, 4'hF, 64'hFF, 4'hF, 64'h0, 1'b1, 1'b0);
    @(negedge clk);
    chk("t5_valA_rnone", o_valA[0], 64'h0);
    drive(4'h2, 4'h9, 4'h0, 4'h9, 64'hAB, 4'hF, 64'h0, 1'b1, 1'b0);
    @(negedge clk);
    chk("t5_n8_valA_id9",  o_valA[1], 64'h0);
    chk("t5_n15_valA_id9", o_valA[0], 64'hAB);

    // 6: asynchronous reset mid-cycle during a write to reg 7
    drive(4'h2, 4'h7, 4'h0, 4'h7, 64'h99, 4'hF, 64'h0, 1'b1, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    chk("t6_valid", 64'(o_valid[0]), 64'h0);
    chk("t6_icode", 64'(o_icode[0]), 64'h0);
    chk("t6_srcA",  64'(o_srcA[0]),  64'hF);
    chk("t6_valA",  o_valA[0],       64'h0);
    @(negedge clk);
    rst_n = 1'b1;
    drive(4'h2, 4'h7, 4'h0, 4'hF, 64'h0, 4'hF, 64'h0, 1'b1, 1'b0);
    @(negedge clk);
    chk("t6_reg7",    o_valA[0], 64'h7);
    chk("t6_n8_reg7", o_valA[1], 64'h7);

    // random traffic against the model
    for (int n = 0; n < 400; n++) begin
      drive(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
            ($urandom_range(0, 3) == 0) ? 4'hF : 4'($urandom_range(0, 15)),
            {$urandom, $urandom},
            ($urandom_range(0, 3) == 0) ? 4'hF : 4'($urandom_range(0, 15)),
            {$urandom, $urandom},
            1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 3) == 0));
      @(negedge clk);
    end

    chk_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
